// File: rtl/opcode_match_decoder.sv
// opcode_match_decoder
//   Two-stage pipelined ternary match table. Each of N entries holds a compare
//   value, a care-mask, a result code and an enable bit. A lookup hits entry i
//   when the entry is enabled and every cared-for bit of in_data equals the
//   compare value. The lowest-index hitting entry wins. A miss returns DEF_CODE.
//
//   Stage 1 registers the hit vector together with a snapshot of the code
//   column. Table writes that land after a lookup has been accepted therefore
//   cannot change that lookup's result. Stage 2 registers the priority-encoded
//   result and drives the output handshake.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_we, cfg_idx          table write strobe and entry index (idx >= N ignored)
//   cfg_match, cfg_mask      compare value and care-mask (1 = bit compared)
//   cfg_code, cfg_en         result code and entry enable
//   in_valid/in_ready        lookup handshake, in_data = field to decode
//   out_valid/out_ready      result handshake
//   out_code/out_hit/out_idx decoded code, hit flag, winning entry
//   hit_cnt/miss_cnt         saturating counts of delivered hits/misses
module opcode_match_decoder #(
  parameter int             IW       = 8,
  parameter int             CW       = 4,
  parameter int             N        = 8,
  parameter logic [CW-1:0]  DEF_CODE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [$clog2(N)-1:0]  cfg_idx,
  input  logic [IW-1:0]         cfg_match,
  input  logic [IW-1:0]         cfg_mask,
  input  logic [CW-1:0]         cfg_code,
  input  logic                  cfg_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IW-1:0]         in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_code,
  output logic                  out_hit,
  output logic [$clog2(N)-1:0]  out_idx,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);

  localparam int IDXW = $clog2(N);

  // Match table
  logic [IW-1:0] match_q [N];
  logic [IW-1:0] match_d [N];
  logic [IW-1:0] mask_q  [N];
  logic [IW-1:0] mask_d  [N];
  logic [CW-1:0] code_q  [N];
  logic [CW-1:0] code_d  [N];
  logic [N-1:0]  en_q, en_d;

  // Pipeline state
  logic          ready_en_q, ready_en_d;
  logic          s1_valid_q, s1_valid_d;
  logic [N-1:0]  s1_hits_q, s1_hits_d;
  logic [CW-1:0] s1_codes_q [N];
  logic [CW-1:0] s1_codes_d [N];
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_code_q, out_code_d;
  logic            out_hit_q, out_hit_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic [15:0]     hit_cnt_q, hit_cnt_d;
  logic [15:0]     miss_cnt_q, miss_cnt_d;

  logic            cfg_ok;
  logic [N-1:0]    hits;
  logic            s2_accept, s1_advance, in_fire, out_fire;
  logic            enc_hit;
  logic [IDXW-1:0] enc_idx;
  logic [CW-1:0]   enc_code;

  // Guards non-power-of-two N, where cfg_idx can address past the table.
  assign cfg_ok = cfg_we && (32'(cfg_idx) < N);

  // Handshake. Stage 2 frees up when empty or being drained this cycle; stage 1
  // may take a new lookup when empty or when it can hand its lookup to stage 2.
  assign s2_accept  = !out_valid_q || out_ready;
  assign s1_advance = !s1_valid_q || s2_accept;
  assign in_ready   = ready_en_q && s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;

  // Table update. The lookup accepted in the same cycle compares against
  // the registered (pre-write) table.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can leave it unassigned and infer a latch.
    match_d = match_q;
    mask_d  = mask_q;
    code_d  = code_q;
    en_d    = en_q;
    if (cfg_ok) begin
      match_d[cfg_idx] = cfg_match;
      mask_d[cfg_idx]  = cfg_mask;
      code_d[cfg_idx]  = cfg_code;
      en_d[cfg_idx]    = cfg_en;
    end
  end

  // Per-entry compare. An all-zero mask compares no bits and so hits anything.
  always_comb begin
    hits = '0;
    for (int i = 0; i < N; i++) begin
      hits[i] = en_q[i] && (((in_data ^ match_q[i]) & mask_q[i]) == '0);
    end
  end

  // Lowest-index priority encoder on the stage-1 hit vector.
  always_comb begin
    enc_hit  = 1'b0;
    enc_idx  = '0;
    enc_code = DEF_CODE;
    for (int i = N - 1; i >= 0; i--) begin
      if (s1_hits_q[i]) begin
        enc_hit  = 1'b1;
        enc_idx  = IDXW'(i);
        enc_code = s1_codes_q[i];
      end
    end
  end

  always_comb begin
    ready_en_d  = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_hits_d   = s1_hits_q;
    s1_codes_d  = s1_codes_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_hit_d   = out_hit_q;
    out_idx_d   = out_idx_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    if (s1_advance) begin
      s1_valid_d = in_fire;
      if (in_fire) begin
        s1_hits_d  = hits;
        s1_codes_d = code_q;
      end
    end

    if (s2_accept) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_code_d = enc_code;
        out_hit_d  = enc_hit;
        out_idx_d  = enc_idx;
      end
    end

    if (out_fire) begin
      if (out_hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  // NOTE: table data and stage-1 payload are not reset; en_q and s1_valid_q gate them, so stale contents are never observed.
  always_ff @(posedge clk) begin
    match_q    <= match_d;
    mask_q     <= mask_d;
    code_q     <= code_d;
    s1_hits_q  <= s1_hits_d;
    s1_codes_q <= s1_codes_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      en_q        <= '0;
      ready_en_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= DEF_CODE;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      en_q        <= en_d;
      ready_en_q  <= ready_en_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_hit_q   <= out_hit_d;
      out_idx_q   <= out_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_hit   = out_hit_q;
  assign out_idx   = out_idx_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_opcode_match_decoder.sv
// Self-checking bench for opcode_match_decoder. A reference table model turns
// each accepted lookup into an expected result that is queued; results are
// popped and compared whenever the DUT delivers an output transfer.
module tb_opcode_match_decoder;

  localparam int IW   = 8;
  localparam int CW   = 4;
  localparam int N    = 8;
  localparam int IDXW = $clog2(N);
  localparam logic [CW-1:0] DEF_CODE = 4'h0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [IDXW-1:0] cfg_idx;
  logic [IW-1:0]   cfg_match, cfg_mask;
  logic [CW-1:0]   cfg_code;
  logic            cfg_en;
  logic            in_valid, in_ready;
  logic [IW-1:0]   in_data;
  logic            out_valid, out_ready;
  logic [CW-1:0]   out_code;
  logic            out_hit;
  logic [IDXW-1:0] out_idx;
  logic [15:0]     hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  opcode_match_decoder #(.IW(IW), .CW(CW), .N(N), .DEF_CODE(DEF_CODE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_match(cfg_match), .cfg_mask(cfg_mask),
    .cfg_code(cfg_code), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_hit(out_hit), .out_idx(out_idx),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct packed {
    logic            hit;
    logic [IDXW-1:0] idx;
    logic [CW-1:0]   code;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];

  logic [IW-1:0] m_match [N];
  logic [IW-1:0] m_mask  [N];
  logic [CW-1:0] m_code  [N];
  logic          m_en    [N];
  logic [15:0]   m_hit, m_miss;

  int   total = 0;
  int   bad   = 0;
  logic last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [IW-1:0] d);
    res_t r;
    r.hit = 1'b0; r.idx = '0; r.code = DEF_CODE;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_en[i] && (((d ^ m_match[i]) & m_mask[i]) == '0)) begin
        r.hit = 1'b1; r.idx = IDXW'(i); r.code = m_code[i];
      end
    end
    return r;
  endfunction

  // Called just after a falling edge with inputs set; evaluates the transfers
  // that the next rising edge will perform, then advances to the next falling edge.
  task automatic step();
    res_t e, g;
    #1;
    check("hit_cnt", 32'(hit_cnt), 32'(m_hit));
    check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      g.hit = out_hit; g.idx = out_idx; g.code = out_code;
      got_q.push_back(g);
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_result", 32'(g), 32'(e));
        if (e.hit) begin
          if (m_hit != 16'hFFFF) m_hit = m_hit + 16'd1;
        end else begin
          if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
        end
      end
    end
    if (last_acc) exp_q.push_back(model(in_data));
    if (rst_n && cfg_we && (32'(cfg_idx) < N)) begin
      m_match[cfg_idx] = cfg_match;
      m_mask[cfg_idx]  = cfg_mask;
      m_code[cfg_idx]  = cfg_code;
      m_en[cfg_idx]    = cfg_en;
    end
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [IDXW-1:0] idx, input logic [IW-1:0] mt,
                           input logic [IW-1:0] mk, input logic [CW-1:0] cd, input logic en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_match = mt; cfg_mask = mk; cfg_code = cd; cfg_en = en;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    do begin
      step(); n++;
    end while (!last_acc && n < 50);
    check("send_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      step(); n++;
    end
    step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_out(input string tag, input int k, input logic hit,
                            input logic [IDXW-1:0] idx, input logic [CW-1:0] code);
    res_t r;
    r.hit = hit; r.idx = idx; r.code = code;
    if (got_q.size() > k) check(tag, 32'(got_q[k]), 32'(r));
    else check(tag, 32'(got_q.size()), 32'(k + 1));
  endtask

  logic [IW-1:0] stall_data [2] = '{8'hB0, 8'hB4};
  res_t snap;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_match = '0; cfg_mask = '0;
    cfg_code = '0; cfg_en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    m_hit = '0; m_miss = '0;
    for (int i = 0; i < N; i++) begin
      m_en[i] = 1'b0; m_match[i] = '0; m_mask[i] = '0; m_code[i] = '0;
    end

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_code", 32'(out_code), 32'(DEF_CODE));
    check("rst_out_hit_idx", {out_hit, out_idx}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_pre_edge", 32'(in_ready), 32'd0);
    step();
    #1 check("ready_after_edge", 32'(in_ready), 32'd1);

    // Empty table miss with two-edge latency
    got_q.delete();
    in_valid = 1'b1; in_data = 8'hBC;
    step();
    in_valid = 1'b0;
    #1 check("lat_edge1", 32'(out_valid), 32'd0);
    step();
    #1 check("lat_edge2", 32'(out_valid), 32'd1);
    drain();
    expect_out("empty_miss", 0, 1'b0, '0, DEF_CODE);
    check("miss_cnt_first", 32'(miss_cnt), 32'd1);

    // Basic decode, back-to-back lookups
    cfg_write(3'd0, 8'hB0, 8'hFF, 4'h8, 1'b1);
    cfg_write(3'd3, 8'h90, 8'hF0, 4'hB, 1'b1);
    got_q.delete();
    send(8'hB0); send(8'h9C); send(8'h48);
    drain();
    expect_out("dec_b0", 0, 1'b1, 3'd0, 4'h8);
    expect_out("dec_9c", 1, 1'b1, 3'd3, 4'hB);
    expect_out("dec_48", 2, 1'b0, 3'd0, DEF_CODE);

    // Priority and disable
    cfg_write(3'd1, 8'hB4, 8'hFF, 4'h1, 1'b1);
    cfg_write(3'd5, 8'hB0, 8'hF0, 4'h5, 1'b1);
    got_q.delete();
    send(8'hB4);
    cfg_write(3'd1, 8'hB4, 8'hFF, 4'h1, 1'b0);
    send(8'hB4);
    drain();
    expect_out("prio_low", 0, 1'b1, 3'd1, 4'h1);
    expect_out("prio_disabled", 1, 1'b1, 3'd5, 4'h5);

    // Write and lookup in the same cycle
    got_q.delete();
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_match = 8'hC3; cfg_mask = 8'hFF; cfg_code = 4'h2; cfg_en = 1'b1;
    in_valid = 1'b1; in_data = 8'hC3;
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    send(8'hC3);
    drain();
    expect_out("same_cycle_wr", 0, 1'b0, 3'd0, DEF_CODE);
    expect_out("after_wr", 1, 1'b1, 3'd2, 4'h2);

    // All-zero mask matches anything
    cfg_write(3'd7, 8'h5A, 8'h00, 4'h7, 1'b1);
    got_q.delete();
    send(8'h48);
    drain();
    expect_out("zero_mask", 0, 1'b1, 3'd7, 4'h7);

    // Full stall: two lookups buffered, outputs held, order kept
    got_q.delete();
    begin
      int acc = 0;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        in_data = (acc < 2) ? stall_data[acc] : 8'h9C;
        step();
        if (last_acc) acc++;
        if (k == 2) begin snap.hit = out_hit; snap.idx = out_idx; snap.code = out_code; end
      end
      check("stall_accepted", 32'(acc), 32'd2);
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_stable", {out_hit, out_idx, out_code}, 32'(snap));
      in_valid = 1'b0;
    end
    drain();
    expect_out("stall_first", 0, 1'b1, 3'd0, 4'h8);
    expect_out("stall_second", 1, 1'b1, 3'd5, 4'h5);
    check("stall_count", 32'(got_q.size()), 32'd2);

    // Random traffic with writes interleaved
    for (int k = 0; k < 400; k++) begin
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_idx   = IDXW'($urandom);
      cfg_match = IW'($urandom);
      cfg_mask  = ($urandom_range(0, 3) == 0) ? 8'h00 : IW'($urandom);
      cfg_code  = CW'($urandom);
      cfg_en    = ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom);
      in_data   = ($urandom_range(0, 1) == 0) ? m_match[$urandom_range(0, N - 1)] : IW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    cfg_we = 1'b0;
    drain();

    // Hit counter saturation
    cfg_write(3'd0, 8'hB0, 8'hFF, 4'h8, 1'b1);
    force dut.hit_cnt_q = 16'hFFFE;
    m_hit = 16'hFFFE;
    step();
    release dut.hit_cnt_q;
    step();
    check("hit_forced", 32'(hit_cnt), 32'hFFFE);
    send(8'hB0); send(8'hB0); send(8'hB0);
    drain();
    check("hit_sat", 32'(hit_cnt), 32'hFFFF);

    // Reset with two lookups in flight
    send(8'hB0); send(8'hB0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    m_hit = '0; m_miss = '0;
    for (int i = 0; i < N; i++) m_en[i] = 1'b0;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;
    got_q.delete();
    repeat (5) step();
    check("midrst_no_output", 32'(got_q.size()), 32'd0);
    send(8'hB0);
    drain();
    expect_out("midrst_en_cleared", 0, 1'b0, 3'd0, DEF_CODE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
